// File: rtl/player_move_ctl.sv
// Player-ship horizontal motion controller: synchronised buttons, one move per frame_tick,
// step size ramping from STEP_MIN to STEP_MAX while a direction is held, clamped to the playfield.
module player_move_ctl #(
    parameter int HOR_PIXELS   = 1024,
    parameter int VER_PIXELS   = 768,
    parameter int SPRITE_W     = 64,
    parameter int Y_OFFSET     = 48,
    parameter int STEP_MIN     = 2,
    parameter int STEP_MAX     = 10,
    parameter int ACCEL_FRAMES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        enable,
    input  logic        button_left,
    input  logic        button_right,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        moving,
    output logic        at_wall,
    output logic [5:0]  speed
);

    typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

    localparam logic [11:0] X_MAX   = 12'(HOR_PIXELS - SPRITE_W);
    localparam logic [11:0] X_START = 12'((HOR_PIXELS - SPRITE_W) / 2);
    localparam logic [11:0] Y_POS   = 12'(VER_PIXELS - Y_OFFSET);
    localparam logic [5:0]  S_MIN   = 6'(STEP_MIN);
    localparam logic [5:0]  S_MAX   = 6'(STEP_MAX);
    localparam int          CNT_W   = $clog2(ACCEL_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCEL_FRAMES - 1);

    logic              r_l_meta, r_l_sync, r_r_meta, r_r_sync;
    state_t            r_state;
    logic [5:0]        r_speed;
    logic [CNT_W-1:0]  r_cnt;
    logic [11:0]       r_xpos;

    state_t            w_req;
    logic [5:0]        w_step;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic signed [12:0] w_x_s, w_step_s, w_x_dec, w_x_inc;
    logic [11:0]       w_x_left, w_x_right, w_x_next;

    // Synchronisers run every clock so a press is ready well before the next tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_l_meta <= 1'b0;
            r_l_sync <= 1'b0;
            r_r_meta <= 1'b0;
            r_r_sync <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep the two flop stages distinct within one edge.
            r_l_meta <= button_left;
            r_l_sync <= r_l_meta;
            r_r_meta <= button_right;
            r_r_sync <= r_r_meta;
        end
    end

    always_comb begin
        // NOTE: default first so no path through this block leaves w_req unassigned (no latch).
        w_req = IDLE;
        if (enable && r_l_sync && !r_r_sync)
            w_req = LEFT;
        else if (enable && r_r_sync && !r_l_sync)
            w_req = RIGHT;
    end

    // A new or reversed direction always restarts at the minimum step.
    assign w_step    = (w_req != r_state) ? S_MIN : r_speed;
    assign w_cnt_inc = r_cnt + 1'b1;

    assign w_x_s     = $signed({1'b0, r_xpos});
    assign w_step_s  = $signed({7'b0, w_step});
    assign w_x_dec   = w_x_s - w_step_s;
    assign w_x_inc   = w_x_s + w_step_s;
    assign w_x_left  = w_x_dec[12] ? 12'd0 : w_x_dec[11:0];
    assign w_x_right = (w_x_inc > $signed({1'b0, X_MAX})) ? X_MAX : w_x_inc[11:0];
    assign w_x_next  = (w_req == LEFT) ? w_x_left : w_x_right;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_speed <= S_MIN;
            r_cnt   <= '0;
            r_xpos  <= X_START;
        end else if (frame_tick) begin
            if (w_req == IDLE) begin
                r_state <= IDLE;
                r_speed <= S_MIN;
                r_cnt   <= '0;
            end else if (w_req != r_state) begin
                r_state <= w_req;
                r_speed <= S_MIN;
                r_cnt   <= '0;
                r_xpos  <= w_x_next;
            end else begin
                r_xpos <= w_x_next;
                // Ramp keeps counting at the wall and at saturation; only speed stops growing.
                if (w_cnt_inc >= CNT_LAST) begin
                    r_cnt <= '0;
                    if (r_speed < S_MAX)
                        r_speed <= r_speed + 1'b1;
                end else begin
                    r_cnt <= w_cnt_inc;
                end
            end
        end
    end

    assign xpos    = r_xpos;
    assign ypos    = Y_POS;
    assign speed   = r_speed;
    assign moving  = (r_state != IDLE);
    assign at_wall = (r_xpos == 12'd0) || (r_xpos == X_MAX);

endmodule

// File: tb/tb_player_move_ctl.sv
// Scoreboard bench for player_move_ctl: a driver pushes expected ship state from a
// frame-level reference model; a monitor pops and compares after every tick or reset.
module tb_player_move_ctl;

    localparam int HOR_PIXELS   = 1024;
    localparam int VER_PIXELS   = 768;
    localparam int SPRITE_W     = 64;
    localparam int Y_OFFSET     = 48;
    localparam int STEP_MIN     = 2;
    localparam int STEP_MAX     = 10;
    localparam int ACCEL_FRAMES = 4;
    localparam int X_MAX        = HOR_PIXELS - SPRITE_W;
    localparam int X_START      = X_MAX / 2;
    localparam int Y_POS        = VER_PIXELS - Y_OFFSET;

    typedef struct {
        string tag;
        int    x;
        int    spd;
        int    mv;
        int    aw;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic        enable = 1'b1;
    logic        button_left = 1'b0;
    logic        button_right = 1'b0;
    logic [11:0] xpos, ypos;
    logic        moving, at_wall;
    logic [5:0]  speed;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;

    // Reference model: direction of the current run and how many ticks it has lasted.
    int   m_x   = X_START;
    int   m_dir = 0;
    int   m_n   = 0;

    player_move_ctl #(
        .HOR_PIXELS(HOR_PIXELS), .VER_PIXELS(VER_PIXELS), .SPRITE_W(SPRITE_W),
        .Y_OFFSET(Y_OFFSET), .STEP_MIN(STEP_MIN), .STEP_MAX(STEP_MAX),
        .ACCEL_FRAMES(ACCEL_FRAMES)
    ) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .enable(enable),
        .button_left(button_left), .button_right(button_right),
        .xpos(xpos), .ypos(ypos), .moving(moving), .at_wall(at_wall), .speed(speed)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Step size reached after n further frames of one run: +1 every ACCEL_FRAMES-1 frames.
    function automatic int spd_of(input int n);
        int s;
        s = STEP_MIN + n / (ACCEL_FRAMES - 1);
        return (s > STEP_MAX) ? STEP_MAX : s;
    endfunction

    function automatic exp_t model_state(input string tag);
        exp_t e;
        e.tag = tag;
        e.x   = m_x;
        e.mv  = (m_dir != 0);
        e.spd = (m_dir == 0) ? STEP_MIN : spd_of(m_n);
        e.aw  = (m_x == 0 || m_x == X_MAX);
        return e;
    endfunction

    function automatic void model_tick(input bit sl, input bit sr, input bit en);
        int req;
        int step;
        req = 0;
        if (en && sl && !sr)      req = -1;
        else if (en && sr && !sl) req = 1;
        if (req == 0) begin
            m_dir = 0;
            m_n   = 0;
        end else begin
            if (req != m_dir) begin
                m_dir = req;
                m_n   = 0;
                step  = STEP_MIN;
            end else begin
                m_n++;
                step = spd_of(m_n - 1);
            end
            m_x = m_x + req * step;
            if (m_x < 0)     m_x = 0;
            if (m_x > X_MAX) m_x = X_MAX;
        end
    endfunction

    // Drive buttons, hold them for `hold` clocks, then one tick. seen_* is what the
    // synchronised path is expected to present at that tick.
    task automatic do_tick(input string tag, input bit l, input bit r, input bit en,
                           input int hold, input bit seen_l, input bit seen_r);
        button_left  = l;
        button_right = r;
        enable       = en;
        repeat (hold) @(negedge clk);
        model_tick(seen_l, seen_r, en);
        exp_q.push_back(model_state(tag));
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic run(input string tag, input bit l, input bit r, input bit en, input int n);
        for (int i = 0; i < n; i++) do_tick(tag, l, r, en, 3, l, r);
    endtask

    task automatic do_reset(input string tag, input bit with_tick);
        @(negedge clk);
        rst        = 1'b1;
        frame_tick = with_tick;
        m_x = X_START;
        m_dir = 0;
        m_n = 0;
        exp_q.push_back(model_state(tag));
        @(negedge clk);
        rst        = 1'b0;
        frame_tick = 1'b0;
    endtask

    // Monitor: the DUT presents a new result on every edge that saw a tick or a reset.
    initial begin
        exp_t e;
        bit   fire;
        forever begin
            @(posedge clk);
            fire = mon_en && (frame_tick || rst);
            if (fire) begin
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    check("scoreboard_underflow", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check({e.tag, ".xpos"},    int'(xpos),    e.x);
                    check({e.tag, ".ypos"},    int'(ypos),    Y_POS);
                    check({e.tag, ".speed"},   int'(speed),   e.spd);
                    check({e.tag, ".moving"},  int'(moving),  e.mv);
                    check({e.tag, ".at_wall"}, int'(at_wall), e.aw);
                end
            end
        end
    end

    initial begin
        int dir;
        int len;
        bit l;
        bit r;
        bit en;
        repeat (3) @(posedge clk);
        mon_en = 1'b1;
        do_reset("reset", 1'b0);

        run("idle", 1'b0, 1'b0, 1'b1, 3);
        run("right_ramp", 1'b0, 1'b1, 1'b1, 6);
        run("left_to_wall", 1'b1, 1'b0, 1'b1, 120);
        run("right_ramp5", 1'b0, 1'b1, 1'b1, 14);
        run("both_held", 1'b1, 1'b1, 1'b1, 2);
        run("right_to_max", 1'b0, 1'b1, 1'b1, 45);
        run("release", 1'b0, 1'b0, 1'b1, 1);
        run("left_restart", 1'b1, 1'b0, 1'b1, 2);
        run("disabled", 1'b1, 1'b0, 1'b0, 3);
        run("left_again", 1'b1, 1'b0, 1'b1, 8);
        run("reversal", 1'b0, 1'b1, 1'b1, 3);

        // A press held only one clock before the tick must not yet be seen.
        run("sync_clear", 1'b0, 1'b0, 1'b1, 1);
        do_tick("sync_early", 1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b0);
        do_tick("sync_seen", 1'b0, 1'b1, 1'b1, 2, 1'b0, 1'b1);

        run("pre_reset_move", 1'b0, 1'b1, 1'b1, 20);
        do_reset("mid_reset", 1'b0);
        run("post_reset", 1'b0, 1'b1, 1'b1, 1);
        run("pre_reset_tick", 1'b0, 1'b1, 1'b1, 5);
        do_reset("reset_with_tick", 1'b1);

        // Random runs of one input pattern, long enough to ramp and reach walls.
        for (int k = 0; k < 40; k++) begin
            dir = $urandom_range(0, 3);
            len = $urandom_range(1, 25);
            l   = (dir == 1) || (dir == 3);
            r   = (dir == 2) || (dir == 3);
            en  = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < len; i++)
                do_tick("random", l, r, en, $urandom_range(2, 4), l, r);
        end

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) check("scoreboard_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
